// File: rtl/reg_file_debug_ctrl.sv
// Debug-side controller for the ID-stage register file debug ports.
// Sequences a full register dump onto a valid/ready byte stream (LSB byte
// first) and arbitrates single-register debug writes so they never collide
// with the dump.
module reg_file_debug_ctrl #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int SIZE_REG = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_dump_start,
  input  logic               i_wr_req,
  input  logic [NB_REG-1:0]  i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  output logic               o_wr_ack,
  output logic               o_busy,
  output logic               o_dump_done,
  output logic [NB_REG-1:0]  o_address_read_debug,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  output logic               o_write_debug_reg_file,
  output logic [NB_REG-1:0]  o_address_write_debug,
  output logic [NB_DATA-1:0] o_write_data_debug,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready
);

  localparam int NB_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    SEND,
    NEXT,
    DONE
  } state_t;

  state_t             state;
  logic [NB_REG-1:0]  index;
  logic [NB_CNT-1:0]  byte_cnt;
  logic [NB_DATA-1:0] shift;
  logic [NB_REG-1:0]  wr_addr_q;
  logic [NB_DATA-1:0] wr_data_q;

  // Control FSM and datapath registers; pending writes take priority in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      index     <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_wr_req) begin
            wr_addr_q <= i_wr_addr;
            wr_data_q <= i_wr_data;
            state     <= WRITE;
          end else if (i_dump_start) begin
            index <= '0;
            state <= READ;
          end
        end
        WRITE: state <= IDLE;
        READ: begin
          shift    <= i_data_read_debug;
          byte_cnt <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (i_tx_ready) begin
            shift    <= shift >> NB_BYTE;
            byte_cnt <= byte_cnt + NB_CNT'(1);
            if (byte_cnt == NB_CNT'(NB_BYTES - 1)) state <= NEXT;
          end
        end
        NEXT: begin
          // Terminal check before increment keeps index from wrapping when
          // SIZE_REG fills the whole address space.
          if (index == NB_REG'(SIZE_REG - 1)) begin
            state <= DONE;
          end else begin
            index <= index + NB_REG'(1);
            state <= READ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore output decode from state and registers.
  always_comb begin
    o_busy                 = (state != IDLE);
    o_wr_ack               = (state == WRITE);
    o_write_debug_reg_file = (state == WRITE);
    o_address_write_debug  = (state == WRITE) ? wr_addr_q : '0;
    o_write_data_debug     = (state == WRITE) ? wr_data_q : '0;
    o_address_read_debug   = index;
    o_tx_valid             = (state == SEND);
    o_tx_data              = (state == SEND) ? shift[NB_BYTE-1:0] : '0;
    o_dump_done            = (state == DONE);
  end

endmodule
